// File: rtl/mdu_seq_ctrl.sv
// Iterative unsigned MULTU/DIVU sequencer with HI/LO registers for the MIPS EX stage.
// One shift-add or restoring-divide step per cycle over WIDTH cycles; busy stalls hazards.
module mdu_seq_ctrl #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic             op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             flush_i,
   input  logic             hi_we_i,
   input  logic             lo_we_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             div_zero_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               op_q, op_d;
   logic               dz_q, dz_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]   low_q, low_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               div_zero_q, div_zero_d;

   logic               accept;
   logic               last_iter;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH:0]     trial;
   logic [WIDTH-1:0]   iter_acc;
   logic [WIDTH-1:0]   iter_low;

   assign accept    = start_i && !flush_i;
   assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

   // acc/low hold {acc_hi, mplr} for MULTU and {rem, quo} for DIVU
   always_comb begin
      mul_sum  = {1'b0, acc_q} + (low_q[0] ? {1'b0, opnd_q} : '0);
      rem_sh   = {acc_q, low_q[WIDTH-1]};
      trial    = rem_sh - {1'b0, opnd_q};
      iter_acc = mul_sum[WIDTH:1];
      iter_low = {mul_sum[0], low_q[WIDTH-1:1]};
      if (op_q) begin
         iter_acc = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
         iter_low = {low_q[WIDTH-2:0], ~trial[WIDTH]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         op_q       <= 1'b0;
         dz_q       <= 1'b0;
         opnd_q     <= '0;
         acc_q      <= '0;
         low_q      <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         div_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         op_q       <= op_d;
         dz_q       <= dz_d;
         opnd_q     <= opnd_d;
         acc_q      <= acc_d;
         low_q      <= low_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         div_zero_q <= div_zero_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (accept) state_d = StRun;
         StRun: begin
            if (flush_i) begin
               state_d = StIdle;
            end else if (dz_q || last_iter) begin
               state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      cnt_d      = cnt_q;
      op_d       = op_q;
      dz_d       = dz_q;
      opnd_d     = opnd_q;
      acc_d      = acc_q;
      low_d      = low_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      div_zero_d = div_zero_q;
      unique case (state_q)
         StIdle: begin
            if (hi_we_i) hi_d = wdata_i;
            if (lo_we_i) lo_d = wdata_i;
            if (accept) begin
               op_d       = op_i;
               cnt_d      = '0;
               acc_d      = '0;
               div_zero_d = 1'b0;
               dz_d       = op_i && (b_i == '0);
               opnd_d     = op_i ? b_i : a_i;
               low_d      = op_i ? a_i : b_i;
            end
         end
         StRun: begin
            if (!flush_i) begin
               if (dz_q) begin
                  // Divide-by-zero finishes after one cycle with the dividend kept in low_q
                  hi_d       = low_q;
                  lo_d       = '1;
                  div_zero_d = 1'b1;
               end else begin
                  acc_d = iter_acc;
                  low_d = iter_low;
                  cnt_d = cnt_q + CNT_W'(1);
                  if (last_iter) begin
                     hi_d = iter_acc;
                     lo_d = iter_low;
                  end
               end
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      busy_o     = (state_q != StIdle);
      done_o     = (state_q == StDone) && !flush_i;
      div_zero_o = div_zero_q;
      hi_o       = hi_q;
      lo_o       = lo_q;
   end

endmodule
